// File: rtl/tartaruga_pkg.sv
// Shared bus/instruction types and fetch constants for the tartaruga core.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;
    typedef logic [31:0] instruction_t;

    localparam bus32_t       RESET_PC_DEFAULT = 32'h0000_0000;
    localparam instruction_t NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        bus32_t       pc;
        instruction_t instr;
    } fetch_entry_t;

    function automatic bus32_t align_word(input bus32_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with flush; head is visible combinationally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues word requests, pairs in-order responses with their
// PCs, buffers them for decode and discards responses made stale by a redirect.
module fetch_stage
    import tartaruga_pkg::*;
#(
    parameter bus32_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int     FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic         imem_req_valid_o,
    input  logic         imem_req_ready_i,
    output bus32_t       imem_req_addr_o,
    input  logic         imem_rsp_valid_i,
    input  instruction_t imem_rsp_data_i,
    input  logic         redirect_i,
    input  bus32_t       redirect_pc_i,
    output bus32_t       pc_o,
    output instruction_t instr_o,
    output logic         valid_o,
    input  logic         ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
        $error("fetch_stage: FIFO_DEPTH must be 2 or 4");
    end

    bus32_t        fetch_pc;
    bus32_t        pcq_head;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] pcq_count;
    logic          buf_full, buf_empty;
    logic          pcq_full, pcq_empty;
    logic          accept, rsp_ok, keep_rsp, pop;
    logic          unused_status;

    // Admission counts in-flight plus buffered so every response has a slot.
    assign imem_req_valid_o = !rst_i && !redirect_i
                              && ((int'(outstanding) + int'(buf_count)) < FIFO_DEPTH);
    assign imem_req_addr_o  = fetch_pc;

    assign accept   = imem_req_valid_o && imem_req_ready_i;
    assign rsp_ok   = imem_rsp_valid_i && !pcq_empty && !rst_i;
    assign keep_rsp = rsp_ok && (drop_cnt == '0) && !redirect_i;
    assign valid_o  = !buf_empty && !rst_i;
    assign pop      = valid_o && ready_i && !redirect_i;
    assign buf_in   = '{pc: pcq_head, instr: imem_rsp_data_i};
    assign pc_o     = valid_o ? buf_head.pc : '0;
    assign instr_o  = valid_o ? buf_head.instr : NOP_INSTR;

    assign outstanding_next = outstanding + CW'(accept) - CW'(rsp_ok);

    // PC queue occupancy mirrors the outstanding counter.
    assign unused_status = ^{pcq_count, pcq_full, buf_full};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (keep_rsp),
        .push_data (buf_in),
        .pop       (pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(bus32_t))
    ) u_pc_queue (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (rsp_ok),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= align_word(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                fetch_pc <= align_word(redirect_pc_i);
                drop_cnt <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus a queue-based
// reference of fetch behaviour (stale-marked in-flight requests, buffered entries).
module tb_fetch_stage;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b1;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        ready_i = 1'b1;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc_o),
        .instr_o          (instr_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i)
    );

    typedef struct { logic [31:0] data; int due; } pend_t;
    typedef struct { logic [31:0] pc; bit stale; } inf_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rsp_hold = 1'b0;
    pend_t       mem_q[$];
    logic [31:0] req_log[$];
    inf_t        m_inf[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc = RST_PC;
    logic        exp_req_valid, exp_valid;
    logic [31:0] exp_addr, exp_pc, exp_instr;
    logic        s_req_valid, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    // One clock cycle: drive memory response, predict, sample, then advance the model.
    task automatic cycle();
        bit   m_rsp;
        inf_t f;
        if (mem_q.size() > 0 && !rsp_hold && (rst_i || mem_q[0].due <= cyc)) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_q[0].data;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        exp_req_valid = !rst_i && !redirect_i && ((m_inf.size() + m_buf.size()) < DEPTH);
        exp_addr      = m_pc;
        exp_valid     = !rst_i && (m_buf.size() > 0);
        exp_pc        = exp_valid ? m_buf[0].pc : 32'h0;
        exp_instr     = exp_valid ? m_buf[0].instr : NOP;
        #1;
        s_req_valid = imem_req_valid_o;
        s_addr      = imem_req_addr_o;
        s_valid     = valid_o;
        s_pc        = pc_o;
        s_instr     = instr_o;
        if (imem_rsp_valid_i) void'(mem_q.pop_front());
        if (imem_req_valid_o && imem_req_ready_i) begin
            req_log.push_back(imem_req_addr_o);
            mem_q.push_back('{$urandom, cyc + lat});
        end
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            m_inf.delete();
            m_buf.delete();
            mem_q.delete();
            m_pc = RST_PC;
        end else begin
            m_rsp = imem_rsp_valid_i && (m_inf.size() > 0);
            if (redirect_i) begin
                m_buf.delete();
                if (m_rsp) void'(m_inf.pop_front());
                foreach (m_inf[k]) m_inf[k].stale = 1'b1;
                m_pc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (exp_valid && ready_i) void'(m_buf.pop_front());
                if (m_rsp) begin
                    f = m_inf.pop_front();
                    if (!f.stale) m_buf.push_back('{f.pc, imem_rsp_data_i});
                end
                if (exp_req_valid && imem_req_ready_i) begin
                    m_inf.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        redirect_i = 1'b0;
        rsp_hold = 1'b0;
        repeat (n) cycle();
        rst_i = 1'b0;
        req_log.delete();
    endtask

    task automatic test_reset();
        ready_i = 1'b1;
        imem_req_ready_i = 1'b1;
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (s_req_valid !== 1'b0 || s_valid !== 1'b0 || s_pc !== 32'h0 || s_instr !== NOP) begin
                n_bad++;
                $display("FAIL reset_outputs: got req_valid=%b valid=%b pc=%h instr=%h, need 0 0 00000000 %h",
                         s_req_valid, s_valid, s_pc, s_instr, NOP);
            end
        end
        rst_i = 1'b0;
        req_log.delete();
        cycle();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_addr !== RST_PC) begin
            n_bad++;
            $display("FAIL reset_first_req: got valid=%b addr=%h, need 1 %h", s_req_valid, s_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        do_reset(2);
        lat = 1;
        ready_i = 1'b1;
        imem_req_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i >= 3) begin
                n_cmp++;
                if (s_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_continuous: cycle %0d valid_o=%b, need 1", i, s_valid);
                end
            end
            n_cmp++;
            if (s_valid !== exp_valid || s_pc !== exp_pc || s_instr !== exp_instr) begin
                n_bad++;
                $display("FAIL stream_head: got %b %h %h, need %b %h %h",
                         s_valid, s_pc, s_instr, exp_valid, exp_pc, exp_instr);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (req_log.size() <= k || req_log[k] !== RST_PC + 32'(4 * k)) begin
                n_bad++;
                $display("FAIL stream_addr%0d: got %h, need %h", k,
                         (req_log.size() > k) ? req_log[k] : 32'hxxxx_xxxx, RST_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        lat = 1;
        ready_i = 1'b0;
        imem_req_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i >= 2) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== RST_PC || s_instr !== exp_instr) begin
                    n_bad++;
                    $display("FAIL bp_head_hold: got %b %h %h, need 1 %h %h",
                             s_valid, s_pc, s_instr, RST_PC, exp_instr);
                end
            end
        end
        n_cmp++;
        if (req_log.size() != DEPTH) begin
            n_bad++;
            $display("FAIL bp_requests: got %0d issued, need %0d", req_log.size(), DEPTH);
        end
        n_cmp++;
        if (s_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_req_low: got %b, need 0", s_req_valid);
        end
        ready_i = 1'b1;
    endtask

    task automatic test_redirect();
        bit seen;
        do_reset(2);
        lat = 5;
        ready_i = 1'b1;
        imem_req_ready_i = 1'b1;
        cycle();
        cycle();
        imem_req_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        cycle();
        n_cmp++;
        if (s_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_no_req: got %b, need 0", s_req_valid);
        end
        redirect_i = 1'b0;
        imem_req_ready_i = 1'b1;
        req_log.delete();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            if (s_valid === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (s_pc !== 32'h0000_0100 || s_instr !== exp_instr) begin
                    n_bad++;
                    $display("FAIL redir_first_pc: got %h %h, need 00000100 %h", s_pc, s_instr, exp_instr);
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL redir_timeout: valid_o never rose, need a 0x100 entry");
        end
        n_cmp++;
        if (req_log.size() == 0 || req_log[0] !== 32'h0000_0100) begin
            n_bad++;
            $display("FAIL redir_req_addr: got %h, need 00000100",
                     (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx);
        end
    endtask

    task automatic test_redirect_unaligned();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        cycle();
        redirect_i = 1'b0;
        req_log.delete();
        for (int i = 0; i < 20 && req_log.size() == 0; i++) cycle();
        n_cmp++;
        if (req_log.size() == 0 || req_log[0] !== 32'h0000_0200) begin
            n_bad++;
            $display("FAIL redir_align: got %h, need 00000200",
                     (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx);
        end
    endtask

    task automatic test_req_stall();
        logic [31:0] next_pc;
        int          n_valid;
        do_reset(2);
        lat = 5;
        ready_i = 1'b1;
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (s_req_valid !== 1'b1 || s_addr !== RST_PC) begin
                n_bad++;
                $display("FAIL stall_addr_hold: got %b %h, need 1 %h", s_req_valid, s_addr, RST_PC);
            end
        end
        imem_req_ready_i = 1'b1;
        next_pc = RST_PC;
        n_valid = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (s_valid === 1'b1) begin
                n_cmp++;
                if (s_pc !== next_pc || s_instr !== exp_instr) begin
                    n_bad++;
                    $display("FAIL stall_order: got %h %h, need %h %h", s_pc, s_instr, next_pc, exp_instr);
                end
                next_pc = next_pc + 32'd4;
                n_valid++;
            end
        end
        n_cmp++;
        if (n_valid < 20) begin
            n_bad++;
            $display("FAIL stall_progress: got %0d instructions, need at least 20", n_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        do_reset(2);
        lat = 3;
        ready_i = 1'b1;
        imem_req_ready_i = 1'b1;
        repeat (5) cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        req_log.delete();
        cycle();
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_valid: got %b, need 0", s_valid);
        end
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_addr !== RST_PC) begin
            n_bad++;
            $display("FAIL rst_mid_restart: got %b %h, need 1 %h", s_req_valid, s_addr, RST_PC);
        end
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            cycle();
            if (s_valid === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (s_pc !== RST_PC || s_instr !== exp_instr) begin
                    n_bad++;
                    $display("FAIL rst_mid_first: got %h %h, need %h %h", s_pc, s_instr, RST_PC, exp_instr);
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rst_mid_timeout: valid_o never rose after reset");
        end
    endtask

    task automatic test_random();
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            ready_i          = ($urandom_range(0, 3) != 0);
            imem_req_ready_i = ($urandom_range(0, 3) != 0);
            lat              = $urandom_range(1, 6);
            rsp_hold         = ($urandom_range(0, 4) == 0);
            redirect_i       = ($urandom_range(0, 24) == 0);
            redirect_pc_i    = $urandom;
            rst_i            = ($urandom_range(0, 199) == 0);
            cycle();
            n_cmp++;
            if (s_req_valid !== exp_req_valid || (exp_req_valid && s_addr !== exp_addr)) begin
                n_bad++;
                $display("FAIL rand_req cycle %0d: got %b %h, need %b %h",
                         cyc, s_req_valid, s_addr, exp_req_valid, exp_addr);
            end
            n_cmp++;
            if (s_valid !== exp_valid || s_pc !== exp_pc || s_instr !== exp_instr) begin
                n_bad++;
                $display("FAIL rand_head cycle %0d: got %b %h %h, need %b %h %h",
                         cyc, s_valid, s_pc, s_instr, exp_valid, exp_pc, exp_instr);
            end
        end
        rst_i = 1'b0;
        redirect_i = 1'b0;
        rsp_hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_unaligned();
        test_req_stall();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, need the test sequence to finish");
        $fatal(1, "watchdog");
    end

endmodule
